// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one asynchronous SRAM between instruction fetch and the
// MEM stage. Each access runs IDLE -> ACCESS -> RELEASE -> IDLE, and the
// pipeline stall lines hold the pipeline while an access is outstanding.
module mem_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk_50MHz,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_data,
    output logic              if_valid,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              stall_front,
    output logic              stall_all,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              ram_data_oe,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
);

    typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

    // Value of the wait counter on the final strobe cycle of an access.
    localparam logic [1:0] WAIT_LAST = 2'(WAIT_CYC);

    state_t     state;
    logic [1:0] wait_cnt;
    logic       last_was_data;
    logic       op_write;
    logic       op_data;

    logic data_req;
    logic grant_fetch;
    logic grant_data;

    // Arbitration: data wins unless it was served last and a fetch is waiting.
    always_comb begin
        data_req    = mem_rd | mem_wr;
        grant_fetch = if_req & (~data_req | last_was_data);
        grant_data  = data_req & ~grant_fetch;
    end

    assign stall_all   = data_req & ~mem_done;
    assign stall_front = stall_all | (if_req & ~if_valid);

    // Access sequencer with registered SRAM strobes and result registers.
    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            wait_cnt      <= 2'd0;
            last_was_data <= 1'b0;
            op_write      <= 1'b0;
            op_data       <= 1'b0;
            ram_addr      <= '0;
            ram_data_o    <= '0;
            ram_data_oe   <= 1'b0;
            ram_ce_n      <= 1'b1;
            ram_oe_n      <= 1'b1;
            ram_we_n      <= 1'b1;
            if_data       <= '0;
            if_valid      <= 1'b0;
            mem_rdata     <= '0;
            mem_done      <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        // A combined rd+wr request is handled as a store.
                        state         <= ACCESS;
                        wait_cnt      <= 2'd0;
                        last_was_data <= 1'b1;
                        op_data       <= 1'b1;
                        op_write      <= mem_wr;
                        ram_addr      <= mem_addr;
                        ram_data_o    <= mem_wdata;
                        ram_ce_n      <= 1'b0;
                        ram_oe_n      <= mem_wr;
                        ram_we_n      <= ~mem_wr;
                        ram_data_oe   <= mem_wr;
                    end else if (grant_fetch) begin
                        state         <= ACCESS;
                        wait_cnt      <= 2'd0;
                        last_was_data <= 1'b0;
                        op_data       <= 1'b0;
                        op_write      <= 1'b0;
                        ram_addr      <= if_addr;
                        ram_ce_n      <= 1'b0;
                        ram_oe_n      <= 1'b0;
                        ram_we_n      <= 1'b1;
                        ram_data_oe   <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (wait_cnt == WAIT_LAST) begin
                        // Last strobe cycle: capture read data and release the bus.
                        state       <= RELEASE;
                        wait_cnt    <= 2'd0;
                        ram_ce_n    <= 1'b1;
                        ram_oe_n    <= 1'b1;
                        ram_we_n    <= 1'b1;
                        ram_data_oe <= 1'b0;
                        if (op_data) begin
                            mem_done <= 1'b1;
                            if (!op_write) begin
                                mem_rdata <= ram_data_i;
                            end
                        end else begin
                            if_valid <= 1'b1;
                            if_data  <= ram_data_i;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                RELEASE: begin
                    // Always pass through IDLE so a still-high old request is not re-granted.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
